// File: rtl/fetch_unit.sv
// Instruction fetch unit and program counter with redirect target LUT and start/done handshake.
// Optional executed-instruction counter enabled by defining FETCH_INSTR_COUNT_EN.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Halt,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic [LUT_W-1:0] TargetIdx,
    input  logic             lut_we,
    input  logic [LUT_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [15:0]      InstrCount
);

    localparam int LUT_DEPTH = 2 ** LUT_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic            start_ok;

    assign start_ok = Start && (state == IDLE || state == DONE);
    assign Running  = (state == RUN);
    assign Done     = (state == DONE);

    // Redirects read lut in the same clock edge that may write it, so they see the old entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        ProgCtr <= StartAddr;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state <= DONE;
                    end else if (jump_en || branch_en) begin
                        ProgCtr <= lut[TargetIdx];
                    end else begin
                        ProgCtr <= ProgCtr + PC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    // Every RUN cycle retires one instruction, the halting one included.
    logic [15:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || start_ok) begin
            count <= '0;
        end else if (state == RUN && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign InstrCount = count;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign InstrCount      = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes reference-model expectations, a monitor pops and compares.
// Honours FETCH_INSTR_COUNT_EN the same way as the design.
module tb_fetch_unit;

    typedef struct {
        bit       rst;
        bit       start;
        bit [9:0] sa;
        bit       halt;
        bit       jmp;
        bit       br;
        bit [4:0] idx;
        bit       we;
        bit [4:0] wa;
        bit [9:0] wd;
    } stim_t;

    typedef struct {
        int pc;
        bit run;
        bit done;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       halt;
    logic       jump_en;
    logic       branch_en;
    logic [4:0] target_idx;
    logic       lut_we;
    logic [4:0] lut_waddr;
    logic [9:0] lut_wdata;
    logic [9:0] prog_ctr;
    logic       running;
    logic       done;
    logic [15:0] instr_count;

    int tests_run = 0;
    int tests_failed = 0;
    bit stim_finished = 0;
    exp_t exp_q[$];

    // Reference model state: plain integers and flags rather than an encoded FSM.
    int m_pc = 0;
    bit m_run = 0;
    bit m_done = 0;
    int m_cnt = 0;
    int m_lut[32];

    fetch_unit dut (
        .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
        .Halt(halt), .jump_en(jump_en), .branch_en(branch_en), .TargetIdx(target_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .ProgCtr(prog_ctr), .Running(running), .Done(done), .InstrCount(instr_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(bit rst, bit st, bit [9:0] sa, bit h, bit j, bit b,
                                 bit [4:0] idx, bit we, bit [4:0] wa, bit [9:0] wd);
        stim_t s;
        s.rst = rst; s.start = st; s.sa = sa; s.halt = h; s.jmp = j; s.br = b;
        s.idx = idx; s.we = we; s.wa = wa; s.wd = wd;
        return s;
    endfunction

    task automatic modelStep(input stim_t s);
        int target;
        if (s.rst) begin
            m_pc = 0; m_run = 0; m_done = 0; m_cnt = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        target = m_lut[s.idx];
        if (!m_run) begin
            if (s.start) begin
                m_pc = s.sa; m_run = 1; m_done = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (s.halt) begin
                m_run = 0; m_done = 1;
            end else if (s.jmp || s.br) begin
                m_pc = target;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        if (s.we) m_lut[s.wa] = s.wd;
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; start = s.start; start_addr = s.sa; halt = s.halt;
        jump_en = s.jmp; branch_en = s.br; target_idx = s.idx;
        lut_we = s.we; lut_waddr = s.wa; lut_wdata = s.wd;
        modelStep(s);
        e.pc = m_pc; e.run = m_run; e.done = m_done;
`ifdef FETCH_INSTR_COUNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (int'(prog_ctr) !== e.pc || running !== e.run || done !== e.done ||
            int'(instr_count) !== e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL cycle_check @%0t: got pc=%h run=%b done=%b cnt=%0d, expected pc=%h run=%b done=%b cnt=%0d",
                     $time, prog_ctr, running, done, instr_count, e.pc[9:0], e.run, e.done, e.cnt);
        end
    endtask

    // Monitor: the design presents its outputs every cycle, one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        stim_t s;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle_cycles(1);

        // Sequential fetch from 0x010.
        applyStimulus(mk(0, 1, 10'h010, 0, 0, 0, 0, 0, 0, 0));
        idle_cycles(4);

        // Redirect through LUT[3].
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 10'h2A0));
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 5'd3, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 1, 1, 5'd3, 0, 0, 0));
        idle_cycles(1);

        // Halt, then wrap around the top of the address space.
        applyStimulus(mk(0, 1, 10'h123, 1, 0, 0, 0, 0, 0, 0));
        idle_cycles(1);
        applyStimulus(mk(0, 1, 10'h3FE, 0, 0, 0, 0, 0, 0, 0));
        idle_cycles(2);
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Run from 0, halt at 5 together with a jump, then restart.
        applyStimulus(mk(0, 1, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        idle_cycles(5);
        applyStimulus(mk(0, 1, 10'h155, 1, 1, 0, 5'd3, 0, 0, 0));
        idle_cycles(2);
        applyStimulus(mk(0, 1, 10'h000, 0, 0, 0, 0, 0, 0, 0));
        idle_cycles(2);

        // Reset mid-run with Start and jump, then show LUT[3] was cleared.
        applyStimulus(mk(1, 1, 10'h200, 0, 1, 0, 5'd3, 0, 0, 0));
        idle_cycles(1);
        applyStimulus(mk(0, 1, 10'h040, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 5'd3, 0, 0, 0));

        // Read-before-write on LUT[7].
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 10'h050));
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 5'd7, 1, 5'd7, 10'h100));
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0));
        idle_cycles(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = mk(($urandom % 150) == 0, ($urandom % 6) == 0, 10'($urandom),
                   ($urandom % 25) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
                   5'($urandom), ($urandom % 3) == 0, 5'($urandom), 10'($urandom));
            applyStimulus(s);
        end

        stim_finished = 1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
